// File: rtl/bilinear_seq_core_if.sv
// Control, source-RAM read and destination-RAM write signals of the bilinear engine.
// The master modport is the engine side; slave is the controller/RAM side.
interface bilinear_seq_core_if #(
  parameter int ADDR_W     = 12,
  parameter int DST_ADDR_W = 14,
  parameter int DIM_W      = 8
);
  logic                  start;
  logic [DIM_W-1:0]      src_w;
  logic [DIM_W-1:0]      src_h;
  logic [DIM_W-1:0]      dst_w;
  logic [DIM_W-1:0]      dst_h;
  logic [15:0]           step;
  logic                  busy;
  logic                  done;
  logic [ADDR_W-1:0]     src_raddr;
  logic [7:0]            src_rdata;
  logic [DST_ADDR_W-1:0] dst_waddr;
  logic [7:0]            dst_wdata;
  logic                  dst_we;

  modport master (
    input  start, src_w, src_h, dst_w, dst_h, step, src_rdata,
    output busy, done, src_raddr, dst_waddr, dst_wdata, dst_we
  );

  modport slave (
    output start, src_w, src_h, dst_w, dst_h, step, src_rdata,
    input  busy, done, src_raddr, dst_waddr, dst_wdata, dst_we
  );
endinterface

// File: rtl/bilinear_seq_core.sv
// Sequential bilinear interpolator: reads 4 source neighbours per destination pixel,
// writes one rounded 8-bit result every 8 cycles in raster order.
module bilinear_seq_core #(
  parameter int ADDR_W     = 12,
  parameter int DST_ADDR_W = 14,
  parameter int DIM_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  bilinear_seq_core_if.master bus
);
  typedef enum logic [3:0] {IDLE, COORD, R00, R01, R10, R11, CAP, HORZ, VERT, DONE} state_t;

  localparam logic [DST_ADDR_W-1:0] DST_ONE = 1;

  state_t           state, nxt;
  logic [DIM_W-1:0] sw, sh, dw, dh, xcnt, ycnt;
  logic [15:0]      stp, ax, ay;
  logic [7:0]       x0, x1, y0, y1, fx, fy;
  logic [7:0]       p00, p01, p10, p11;
  logic [7:0]       cx0, cx1, cy0, cy1, cfx, cfy;
  logic [8:0]       wx, wy;
  logic [15:0]      top_c, bot_c;
  logic [7:0]       pix_c;
  logic             last_x, last_y, empty;

  function automatic logic [ADDR_W-1:0] raddr(input logic [7:0] y, input logic [7:0] x,
                                               input logic [DIM_W-1:0] w);
    return ADDR_W'(16'(y) * 16'(w) + 16'(x));
  endfunction

  assign last_x = (xcnt == dw - 1'b1);
  assign last_y = (ycnt == dh - 1'b1);
  assign empty  = (dw == '0) || (dh == '0);

  // Integer part saturates at the last column/row, where the fraction is dropped.
  always_comb begin
    cx0 = ax[15:8];
    cfx = ax[7:0];
    cy0 = ay[15:8];
    cfy = ay[7:0];
    if (cx0 >= sw - 8'd1) begin
      cx0 = sw - 8'd1;
      cfx = '0;
    end
    if (cy0 >= sh - 8'd1) begin
      cy0 = sh - 8'd1;
      cfy = '0;
    end
    cx1 = (cx0 == sw - 8'd1) ? cx0 : cx0 + 8'd1;
    cy1 = (cy0 == sh - 8'd1) ? cy0 : cy0 + 8'd1;
  end

  always_comb begin
    wx    = 9'd256 - {1'b0, fx};
    wy    = 9'd256 - {1'b0, fy};
    top_c = {8'd0, p00} * {7'd0, wx} + {8'd0, p01} * {8'd0, fx};
    bot_c = {8'd0, p10} * {7'd0, wx} + {8'd0, p11} * {8'd0, fx};
    pix_c = 8'(({9'd0, top_c} * {16'd0, wy} + {9'd0, bot_c} * {17'd0, fy} + 25'd32768) >> 16);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = COORD;
      COORD:   nxt = empty ? DONE : R00;
      R00:     nxt = R01;
      R01:     nxt = R10;
      R10:     nxt = R11;
      R11:     nxt = CAP;
      CAP:     nxt = HORZ;
      HORZ:    nxt = VERT;
      VERT:    nxt = (last_x && last_y) ? DONE : COORD;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Status strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busy <= 1'b0;  bus.done <= 1'b0;  bus.dst_we <= 1'b0;
      bus.src_raddr <= '0;  bus.dst_waddr <= '0;  bus.dst_wdata <= '0;
      sw <= '0;  sh <= '0;  dw <= '0;  dh <= '0;  stp <= '0;
      ax <= '0;  ay <= '0;  xcnt <= '0;  ycnt <= '0;
      x0 <= '0;  x1 <= '0;  y0 <= '0;  y1 <= '0;  fx <= '0;  fy <= '0;
      p00 <= '0;  p01 <= '0;  p10 <= '0;  p11 <= '0;
    end else begin
      bus.busy   <= (nxt != IDLE) && (nxt != DONE);
      bus.done   <= (nxt == DONE);
      bus.dst_we <= (nxt == VERT);
      case (state)
        IDLE: if (bus.start) begin
          sw <= bus.src_w;  sh <= bus.src_h;  dw <= bus.dst_w;  dh <= bus.dst_h;
          stp <= bus.step;
          ax <= '0;  ay <= '0;  xcnt <= '0;  ycnt <= '0;
          bus.dst_waddr <= '0;
        end
        COORD: begin
          x0 <= cx0;  x1 <= cx1;  y0 <= cy0;  y1 <= cy1;  fx <= cfx;  fy <= cfy;
          bus.src_raddr <= raddr(cy0, cx0, sw);
        end
        R00: bus.src_raddr <= raddr(y0, x1, sw);
        R01: begin
          bus.src_raddr <= raddr(y1, x0, sw);
          p00 <= bus.src_rdata;
        end
        R10: begin
          bus.src_raddr <= raddr(y1, x1, sw);
          p01 <= bus.src_rdata;
        end
        R11:  p10 <= bus.src_rdata;
        CAP:  p11 <= bus.src_rdata;
        HORZ: bus.dst_wdata <= pix_c;
        VERT: begin
          bus.dst_waddr <= bus.dst_waddr + DST_ONE;
          if (last_x) begin
            xcnt <= '0;
            ax   <= '0;
            ay   <= ay + stp;
            ycnt <= ycnt + 1'b1;
          end else begin
            xcnt <= xcnt + 1'b1;
            ax   <= ax + stp;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bilinear_seq_core.sv
// Randomized and directed frames against a plain-arithmetic bilinear reference model.
module tb_bilinear_seq_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bilinear_seq_core_if bif ();
  bilinear_seq_core dut (.clk(clk), .rst(rst), .bus(bif));

  logic [7:0] src_mem [0:4095];
  always @(posedge clk) bif.src_rdata <= src_mem[bif.src_raddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int e0 = 0;
  bit mon_en = 1'b0;
  int wa_q[$];
  int wd_q[$];
  int first_we, done_cyc, done_cnt, busy_cnt;

  always @(negedge clk) if (mon_en) begin
    if (bif.dst_we) begin
      if (wa_q.size() == 0) first_we = cyc - e0;
      wa_q.push_back(int'(bif.dst_waddr));
      wd_q.push_back(int'(bif.dst_wdata));
    end
    if (bif.busy) busy_cnt++;
    if (bif.done) begin
      done_cnt++;
      done_cyc = cyc - e0;
    end
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_pix(input int sw, input int sh, input int i, input int j, input int st);
    int ax, ay, x0, y0, x1, y1, fx, fy, top, bot;
    ax = (i * st) % 65536;
    ay = (j * st) % 65536;
    x0 = ax / 256;  fx = ax % 256;
    y0 = ay / 256;  fy = ay % 256;
    if (x0 >= sw - 1) begin x0 = sw - 1; fx = 0; end
    if (y0 >= sh - 1) begin y0 = sh - 1; fy = 0; end
    x1 = (x0 + 1 < sw) ? x0 + 1 : sw - 1;
    y1 = (y0 + 1 < sh) ? y0 + 1 : sh - 1;
    top = src_mem[y0*sw + x0] * (256 - fx) + src_mem[y0*sw + x1] * fx;
    bot = src_mem[y1*sw + x0] * (256 - fx) + src_mem[y1*sw + x1] * fx;
    return (top * (256 - fy) + bot * fy + 32768) / 65536;
  endfunction

  task automatic launch(input int sw, input int sh, input int dw, input int dh, input int st);
    @(negedge clk);
    bif.src_w = 8'(sw);  bif.src_h = 8'(sh);
    bif.dst_w = 8'(dw);  bif.dst_h = 8'(dh);
    bif.step  = 16'(st);
    wa_q.delete();  wd_q.delete();
    first_we = -1;  done_cyc = -1;  done_cnt = 0;  busy_cnt = 0;
    e0 = cyc;
    mon_en = 1'b1;
    bif.start = 1'b1;
  endtask

  task automatic run_frame(input string name, input int sw, input int sh, input int dw,
                           input int dh, input int st, input bit interfere);
    int n;
    n = dw * dh;
    launch(sw, sh, dw, dh, st);
    for (int k = 0; k < 8*n + 40 && done_cnt == 0; k++) begin
      @(negedge clk); #1;
      bif.start = interfere && ((cyc - e0) == 20);
      if (bif.start) begin
        bif.src_w = 8'd3;  bif.dst_w = 8'd2;  bif.dst_h = 8'd2;  bif.step = 16'd77;
      end
    end
    check_eq({name, "_done_seen"}, done_cnt > 0, 1);
    repeat (3) @(negedge clk);
    #1 mon_en = 1'b0;
    check_eq({name, "_done_cnt"}, done_cnt, 1);
    check_eq({name, "_done_cyc"}, done_cyc, (n == 0) ? 2 : 8*n + 1);
    check_eq({name, "_nwrites"}, wa_q.size(), n);
    if (n > 0) begin
      check_eq({name, "_first_we"}, first_we, 8);
      check_eq({name, "_busy_cycles"}, busy_cnt, 8*n);
    end
    for (int k = 0; k < wa_q.size() && k < n; k++) begin
      check_eq($sformatf("%s_addr%0d", name, k), wa_q[k], k);
      check_eq($sformatf("%s_data%0d", name, k), wd_q[k], ref_pix(sw, sh, k % dw, k / dw, st));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sw, sh, dw, dh, st;
    bif.start = 1'b0;  bif.src_w = '0;  bif.src_h = '0;
    bif.dst_w = '0;  bif.dst_h = '0;  bif.step = '0;
    for (int a = 0; a < 4096; a++) src_mem[a] = 8'($urandom_range(0, 255));
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", bif.busy, 0);
    check_eq("rst_done", bif.done, 0);
    check_eq("rst_we", bif.dst_we, 0);
    check_eq("rst_raddr", bif.src_raddr, 0);
    check_eq("rst_waddr", bif.dst_waddr, 0);
    check_eq("rst_wdata", bif.dst_wdata, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int a = 0; a < 16; a++) src_mem[a] = 8'(a);
    run_frame("ident", 4, 4, 4, 4, 256, 1'b0);
    for (int a = 0; a < 16; a++) check_eq($sformatf("ident_src%0d", a), (a < wd_q.size()) ? wd_q[a] : -1, a);

    src_mem[0] = 8'd0;  src_mem[1] = 8'd100;  src_mem[2] = 8'd200;  src_mem[3] = 8'd50;
    run_frame("up2x", 2, 2, 4, 4, 128, 1'b0);
    if (wd_q.size() == 16) begin
      check_eq("up2x_a1", wd_q[1], 50);
      check_eq("up2x_a3", wd_q[3], 100);
      check_eq("up2x_a5", wd_q[5], 88);
      check_eq("up2x_a15", wd_q[15], 50);
    end else check_eq("up2x_size", wd_q.size(), 16);

    run_frame("zero", 4, 4, 0, 4, 256, 1'b0);

    for (int a = 0; a < 16; a++) src_mem[a] = 8'($urandom_range(0, 255));
    run_frame("busy_start", 4, 4, 4, 4, 256, 1'b1);

    launch(4, 4, 4, 4, 256);
    for (int k = 0; k < 200 && wa_q.size() < 3; k++) begin
      @(negedge clk); #1;
      bif.start = 1'b0;
    end
    check_eq("mid_writes", wa_q.size(), 3);
    check_eq("mid_we_before", bif.dst_we, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_we", bif.dst_we, 0);
    check_eq("mid_rst_busy", bif.busy, 0);
    check_eq("mid_rst_waddr", bif.dst_waddr, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1 mon_en = 1'b0;
    check_eq("mid_no_done", done_cnt, 0);
    run_frame("restart", 4, 4, 4, 4, 256, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 256; a++) src_mem[a] = 8'($urandom_range(0, 255));
      sw = $urandom_range(1, 12);  sh = $urandom_range(1, 12);
      dw = $urandom_range(1, 6);   dh = $urandom_range(1, 6);
      st = $urandom_range(0, 700);
      run_frame($sformatf("rnd%0d", r), sw, sh, dw, dh, st, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
